// File: rtl/meter_pwm_array_if.sv
// Calibration write bus for the meter PWM array: one strobe, channel, select, data.
interface meter_pwm_array_if;
    logic        cfg_we;
    logic [2:0]  cfg_ch;
    logic        cfg_sel;
    logic [15:0] cfg_data;

    // Producer of calibration writes
    modport master (
        output cfg_we,
        output cfg_ch,
        output cfg_sel,
        output cfg_data
    );

    // Consumer of calibration writes
    modport slave (
        input cfg_we,
        input cfg_ch,
        input cfg_sel,
        input cfg_data
    );
endinterface

// File: rtl/meter_pwm_array.sv
// Multi-channel calibrated PWM driver for moving-coil meter needles.
// Position index -> gain/offset calibrated target -> slew-limited applied duty
// (updated only at period boundaries) -> registered glitch-free PWM output.
module meter_pwm_array #(
    parameter int unsigned CHANNELS  = 3,
    parameter int unsigned IDX_W     = 8,
    parameter int unsigned DUTY_W    = 15,
    parameter int unsigned SLEW_STEP = 64
) (
    input  logic                      clk,
    input  logic                      Rst,
    input  logic [CHANNELS-1:0]       En,
    input  logic [CHANNELS*IDX_W-1:0] idx_i,
    meter_pwm_array_if.slave          cfg,
    output logic [CHANNELS-1:0]       pwm_o,
    output logic [CHANNELS-1:0]       settled_o,
    output logic                      period_strobe_o
);

    localparam int unsigned PROD_W = IDX_W + 16;
    localparam int unsigned SUM_W  = IDX_W + 17;
    localparam logic [DUTY_W-1:0] DUTY_MAX = '1;
    localparam logic [SUM_W-1:0]  SAT      = SUM_W'(DUTY_MAX);
    localparam logic [15:0]       GAIN_ONE = 16'h0100;

    logic [DUTY_W-1:0] r_cnt;
    logic [15:0]       r_gain   [CHANNELS];
    logic [15:0]       r_offset [CHANNELS];
    logic [DUTY_W-1:0] r_tgt    [CHANNELS];
    logic [DUTY_W-1:0] r_cur    [CHANNELS];

    logic [PROD_W-1:0] w_prod   [CHANNELS];
    logic [SUM_W-1:0]  w_sum    [CHANNELS];
    logic [DUTY_W-1:0] w_tgt    [CHANNELS];
    logic [DUTY_W-1:0] w_next   [CHANNELS];
    logic              w_strobe;

    assign w_strobe = (r_cnt == DUTY_MAX);

    // Calibrated saturating target and slew-limited next duty per channel
    always_comb begin
        for (int c = 0; c < CHANNELS; c++) begin
            w_prod[c] = PROD_W'(idx_i[c*IDX_W +: IDX_W]) * PROD_W'(r_gain[c]);
            w_sum[c]  = SUM_W'(r_offset[c]) + SUM_W'(w_prod[c] >> 8);
            w_tgt[c]  = (w_sum[c] > SAT) ? DUTY_MAX : DUTY_W'(w_sum[c]);

            w_next[c] = r_tgt[c];
            if (!En[c]) begin
                w_next[c] = '0;
            end else if (r_tgt[c] > r_cur[c]) begin
                if (SLEW_STEP != 0 && 32'(r_tgt[c] - r_cur[c]) > SLEW_STEP)
                    w_next[c] = r_cur[c] + DUTY_W'(SLEW_STEP);
            end else begin
                if (SLEW_STEP != 0 && 32'(r_cur[c] - r_tgt[c]) > SLEW_STEP)
                    w_next[c] = r_cur[c] - DUTY_W'(SLEW_STEP);
            end
        end
    end

    // Shared period counter and end-of-period strobe aligned to cnt = max
    always_ff @(posedge clk) begin
        if (Rst) begin
            r_cnt           <= '0;
            period_strobe_o <= 1'b0;
        end else begin
            r_cnt           <= r_cnt + DUTY_W'(1);
            period_strobe_o <= (r_cnt == DUTY_MAX - DUTY_W'(1));
        end
    end

    // Calibration registers; writes to channels beyond CHANNELS fall through
    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_gain[c]   <= GAIN_ONE;
                r_offset[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                if (cfg.cfg_we && cfg.cfg_ch == 3'(c)) begin
                    if (cfg.cfg_sel) r_offset[c] <= cfg.cfg_data;
                    else             r_gain[c]   <= cfg.cfg_data;
                end
            end
        end
    end

    // Target every clock; applied duty only on the strobe cycle so it never changes mid-period
    always_ff @(posedge clk) begin
        if (Rst) begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_tgt[c] <= '0;
                r_cur[c] <= '0;
            end
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                r_tgt[c] <= w_tgt[c];
                if (w_strobe) r_cur[c] <= w_next[c];
            end
        end
    end

    // Registered PWM and settled flags; enable gates both immediately
    always_ff @(posedge clk) begin
        if (Rst) begin
            pwm_o     <= '0;
            settled_o <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                pwm_o[c]     <= En[c] & (r_cnt < r_cur[c]);
                settled_o[c] <= En[c] & (r_cur[c] == r_tgt[c]);
            end
        end
    end

endmodule

// File: tb/tb_meter_pwm_array.sv
// Bench for meter_pwm_array: two instances (slew 8 and slew 0) share stimulus;
// per-period pulse widths and settled flags are predicted and checked at each strobe.
module tb_meter_pwm_array;

    localparam int CH  = 3;
    localparam int PER = 64;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] en;
    logic [23:0] idx;
    logic [2:0] pwm_a, set_a, pwm_b, set_b;
    logic       stb_a, stb_b;

    always #5 clk = ~clk;

    meter_pwm_array_if cfg_bus ();

    meter_pwm_array #(.CHANNELS(3), .IDX_W(8), .DUTY_W(6), .SLEW_STEP(8)) u_dut (
        .clk(clk), .Rst(rst), .En(en), .idx_i(idx), .cfg(cfg_bus),
        .pwm_o(pwm_a), .settled_o(set_a), .period_strobe_o(stb_a)
    );

    meter_pwm_array #(.CHANNELS(3), .IDX_W(8), .DUTY_W(6), .SLEW_STEP(0)) u_dut_ns (
        .clk(clk), .Rst(rst), .En(en), .idx_i(idx), .cfg(cfg_bus),
        .pwm_o(pwm_b), .settled_o(set_b), .period_strobe_o(stb_b)
    );

    typedef struct packed {
        logic [2:0][6:0] wa;
        logic [2:0][6:0] wb;
        logic [2:0]      sa;
        logic [2:0]      sb;
    } exp_t;

    exp_t q[$];
    int checks   = 0;
    int failures = 0;

    // reference model state
    int         m_gain[CH];
    int         m_off[CH];
    int         m_cur_a[CH];
    int         m_cur_b[CH];
    logic [2:0] m_en;
    int         pos;
    bit         fresh;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    function automatic int f_tgt(input int ix, input int g, input int o);
        longint t;
        t = longint'(o) + ((longint'(ix) * longint'(g)) / 256);
        return (t > PER - 1) ? PER - 1 : int'(t);
    endfunction

    function automatic int f_slew(input int cur, input int tgt, input int s);
        if (s == 0) return tgt;
        if (tgt > cur) return (tgt - cur <= s) ? tgt : cur + s;
        return (cur - tgt <= s) ? tgt : cur - s;
    endfunction

    // high cycles in a period with duty cur when enable switches old->new at cycle a
    function automatic int f_width(input int cur, input int a, input logic e_old, input logic e_new);
        int w;
        w = 0;
        if (e_old) w += (cur < a) ? cur : a;
        if (e_new) w += (cur > a) ? cur - a : 0;
        return w;
    endfunction

    task automatic model_reset();
        for (int c = 0; c < CH; c++) begin
            m_gain[c]  = 256;
            m_off[c]   = 0;
            m_cur_a[c] = 0;
            m_cur_b[c] = 0;
        end
        m_en = en;
    endtask

    task automatic goto_cycle(input int a);
        int n;
        n = (fresh && a >= pos) ? a - pos : PER - pos + a;
        repeat (n) @(posedge clk);
        #1;
        pos   = a;
        fresh = 0;
    endtask

    // Apply new inputs at cycle a of the next period and queue that period's expectation
    task automatic step(input int a, input logic [2:0] ne, input int i0, input int i1, input int i2,
                        input bit we, input int ch, input bit sel, input int data);
        exp_t e;
        int   ix[CH];
        int   t;
        goto_cycle(a);
        idx              = {8'(i2), 8'(i1), 8'(i0)};
        en               = ne;
        cfg_bus.cfg_we   = we;
        cfg_bus.cfg_ch   = 3'(ch);
        cfg_bus.cfg_sel  = sel;
        cfg_bus.cfg_data = 16'(data);
        if (we && ch < CH) begin
            if (sel) m_off[ch] = data;
            else     m_gain[ch] = data;
        end
        ix = '{i0, i1, i2};
        e  = '0;
        for (int c = 0; c < CH; c++) begin
            t        = f_tgt(ix[c], m_gain[c], m_off[c]);
            e.wa[c]  = 7'(f_width(m_cur_a[c], a, m_en[c], ne[c]));
            e.wb[c]  = 7'(f_width(m_cur_b[c], a, m_en[c], ne[c]));
            e.sa[c]  = ne[c] && (m_cur_a[c] == t);
            e.sb[c]  = ne[c] && (m_cur_b[c] == t);
            m_cur_a[c] = ne[c] ? f_slew(m_cur_a[c], t, 8) : 0;
            m_cur_b[c] = ne[c] ? f_slew(m_cur_b[c], t, 0) : 0;
        end
        m_en = ne;
        q.push_back(e);
        @(posedge clk);
        #1;
        cfg_bus.cfg_we = 1'b0;
        pos = a + 1;
    endtask

    // Monitor: accumulate pulse widths, compare against the scoreboard at every strobe
    int   len = 0;
    int   cnt_a[CH];
    int   cnt_b[CH];
    exp_t mon_e;

    always @(negedge clk) begin
        if (rst) begin
            len = 0;
            for (int c = 0; c < CH; c++) begin
                cnt_a[c] = 0;
                cnt_b[c] = 0;
            end
        end else begin
            len++;
            for (int c = 0; c < CH; c++) begin
                cnt_a[c] += int'(pwm_a[c]);
                cnt_b[c] += int'(pwm_b[c]);
            end
            if (stb_a) begin
                chk("period_len", len, PER);
                chk("strobe_b", int'(stb_b), 1);
                if (q.size() == 0) begin
                    chk("sb_empty", 0, 1);
                end else begin
                    mon_e = q.pop_front();
                    for (int c = 0; c < CH; c++) begin
                        chk($sformatf("width_a%0d", c), cnt_a[c], int'(mon_e.wa[c]));
                        chk($sformatf("width_b%0d", c), cnt_b[c], int'(mon_e.wb[c]));
                    end
                    chk("settled_a", int'(set_a), int'(mon_e.sa));
                    chk("settled_b", int'(set_b), int'(mon_e.sb));
                end
                len = 0;
                for (int c = 0; c < CH; c++) begin
                    cnt_a[c] = 0;
                    cnt_b[c] = 0;
                end
            end
        end
    end

    initial begin
        int guard;
        logic [2:0] re;
        rst              = 1'b1;
        en               = 3'b111;
        idx              = '0;
        cfg_bus.cfg_we   = 1'b0;
        cfg_bus.cfg_ch   = '0;
        cfg_bus.cfg_sel  = 1'b0;
        cfg_bus.cfg_data = '0;
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_pwm", int'({pwm_a, pwm_b}), 0);
        chk("rst_settled", int'({set_a, set_b}), 0);
        chk("rst_strobe", int'({stb_a, stb_b}), 0);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        pos   = 0;
        fresh = 1;
        model_reset();
        @(negedge clk);
        chk("settled_cyc0", int'(set_a), 0);
        @(posedge clk);
        #1;
        pos = 1;
        @(negedge clk);
        chk("settled_cyc1_a", int'(set_a), 7);
        chk("settled_cyc1_b", int'(set_b), 7);

        // idle at zero, then ramps toward 40 / 50 / 48
        step(2, 3'b111, 0, 0, 0, 0, 0, 0, 0);
        repeat (7) step(10, 3'b111, 40, 50, 48, 0, 0, 0, 0);
        // ch1 gain 2.0 then offset 10: target saturates
        step(5, 3'b111, 40, 200, 48, 1, 1, 0, 16'h0200);
        step(5, 3'b111, 40, 200, 48, 1, 1, 1, 10);
        repeat (8) step(20, 3'b111, 40, 200, 48, 0, 0, 0, 0);
        // drop ch2 enable mid-period at duty 48, hold off a full period, re-enable
        step(30, 3'b011, 40, 200, 48, 0, 0, 0, 0);
        step(30, 3'b011, 40, 200, 48, 0, 0, 0, 0);
        step(3, 3'b111, 40, 200, 48, 0, 0, 0, 0);
        repeat (6) step(20, 3'b111, 40, 200, 48, 0, 0, 0, 0);
        // writes to a channel that does not exist
        step(7, 3'b111, 40, 200, 48, 1, 5, 0, 0);
        step(7, 3'b111, 40, 200, 48, 1, 5, 1, 63);
        repeat (2) step(7, 3'b111, 40, 200, 48, 0, 0, 0, 0);

        // randomized traffic
        repeat (30) begin
            re = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b111;
            step($urandom_range(2, 50), re,
                 $urandom_range(0, 80), $urandom_range(0, 255), $urandom_range(0, 80),
                 $urandom_range(0, 1) == 1, $urandom_range(0, 7), 1'b0, 0);
            if (cfg_bus.cfg_data == 16'h0) begin end
        end
        repeat (6) begin
            bit sel;
            sel = $urandom_range(0, 1) == 1;
            step($urandom_range(2, 50), 3'b111,
                 $urandom_range(0, 80), $urandom_range(0, 80), $urandom_range(0, 80),
                 1'b1, $urandom_range(0, 7), sel,
                 sel ? $urandom_range(0, 40) : $urandom_range(0, 16'h0300));
        end
        step(10, 3'b111, 60, 60, 60, 0, 0, 0, 0);

        // reset in the middle of a period: outputs clear, period restarts, calibration defaults
        goto_cycle(19);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst   = 1'b0;
        pos   = 0;
        fresh = 1;
        model_reset();
        @(negedge clk);
        chk("midrst_pwm", int'({pwm_a, pwm_b}), 0);
        chk("midrst_settled", int'({set_a, set_b}), 0);
        chk("midrst_strobe", int'({stb_a, stb_b}), 0);
        repeat (4) step(4, 3'b111, 30, 20, 10, 0, 0, 0, 0);

        guard = 0;
        while (q.size() > 0 && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        chk("drain", q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
